// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline multiply/divide unit: op codes, FSM states, counter width.
package pipe_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FIXUP = 2'b10
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the multi-cycle datapath: a shift-add multiply step or a restoring divide step
// on the partial {acc,q}.
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, operand} : '0);
    rem      = {acc, q[WIDTH-1]};
    diff     = rem - {1'b0, operand};
    acc_next = acc;
    q_next   = q;
    if (is_div) begin
      // acc < operand holds between steps, so diff[WIDTH] is a clean borrow flag
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/pipe_muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with HI/LO registers, sitting beside the EX-stage ALU.
//   state   | meaning
//   S_IDLE  | waiting for start; mthi/mtlo writes accepted
//   S_RUN   | WIDTH iteration cycles on magnitudes, counter WIDTH-1..0
//   S_FIXUP | sign correction and HI/LO write, done pulse follows
module pipe_muldiv_unit
  import pipe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   acc_q, q_q, opnd_q;
  logic [WIDTH-1:0]   acc_nx, q_nx;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div_q, neg_main_q, neg_rem_q, dz_q;
  logic               done_q, div_zero_q;

  logic               sgn_in, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .q        (q_q),
    .operand  (opnd_q),
    .is_div   (is_div_q),
    .acc_next (acc_nx),
    .q_next   (q_nx)
  );

  always_comb begin
    sgn_in = SIGNED_EN && op_is_signed(op);
    a_neg  = sgn_in & src_a[WIDTH-1];
    b_neg  = sgn_in & src_b[WIDTH-1];
    abs_a  = a_neg ? -src_a : src_a;
    abs_b  = b_neg ? -src_b : src_b;
  end

  always_comb begin
    prod_raw = {acc_q, q_q};
    prod_fix = neg_main_q ? -prod_raw : prod_raw;
    quo_fix  = dz_q ? '1 : (neg_main_q ? -q_q : q_q);
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (flush)              state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FIXUP;
      end
      S_FIXUP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            cnt_q      <= CNT_TOP;
            acc_q      <= '0;
            is_div_q   <= op_is_div(op);
            neg_main_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            dz_q       <= op_is_div(op) && (src_b == '0);
            // Divide iterates over the dividend bits; multiply iterates over the multiplier bits
            if (op_is_div(op)) begin
              q_q    <= abs_a;
              opnd_q <= abs_b;
            end else begin
              q_q    <= abs_b;
              opnd_q <= abs_a;
            end
          end
        end
        S_RUN: begin
          if (!flush) begin
            acc_q <= acc_nx;
            q_q   <= q_nx;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIXUP: begin
          if (!flush) begin
            if (is_div_q) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q     <= 1'b1;
            div_zero_q <= dz_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
